// File: rtl/minmax_reduce_int.sv
// minmax_reduce_int: streaming signed/unsigned min/max reduction over valid/ready frames.
// Optional MINMAX_REDUCE_ARGIDX_EN keeps the first-occurrence index register; otherwise out_index is 0.
module gt_int_nbit #(
   parameter int N         = 32,
   parameter int IMPL_TYPE = 0
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         gt
);
   generate
      if (IMPL_TYPE == 0) begin : g_cmp
         assign gt = $signed(a) > $signed(b);
      end else begin : g_sub
         // sign of the widened difference decides, nonzero rules out equality
         logic [N:0] diff;
         assign diff = {a[N-1], a} - {b[N-1], b};
         assign gt   = ~diff[N] & (|diff);
      end
   endgenerate
endmodule

module minmax_reduce_int #(
   parameter int WIDTH     = 32,
   parameter int IMPL_TYPE = 0,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_max,
   input  logic             cfg_signed,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_index,
   output logic [CNT_W-1:0] out_count
);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   state_t           state, state_d;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             mode_max, mode_signed;
   logic             beat, replace;
   logic [WIDTH-1:0] flip, cmp_a, cmp_b;
   // unsigned compare reuses the signed comparator by flipping both MSBs
   assign flip  = {~mode_signed, {(WIDTH-1){1'b0}}};
   assign cmp_a = (mode_max ? in_data : acc) ^ flip;
   assign cmp_b = (mode_max ? acc : in_data) ^ flip;
   gt_int_nbit #(.N(WIDTH), .IMPL_TYPE(IMPL_TYPE)) u_gt (
      .a  (cmp_a),
      .b  (cmp_b),
      .gt (replace)
   );
   assign in_ready  = state != DONE;
   assign beat      = in_valid & in_ready;
   assign out_valid = state == DONE;
   assign out_data  = out_valid ? acc : '0;
   assign out_count = out_valid ? cnt : '0;
   always_comb begin
      state_d = state;
      if (beat) state_d = in_last ? DONE : ACCUM;
      if (out_valid && out_ready) state_d = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_d;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc         <= '0;
         cnt         <= '0;
         mode_max    <= 1'b0;
         mode_signed <= 1'b0;
      end else if (beat) begin
         if (state == IDLE) begin
            acc         <= in_data;
            cnt         <= CNT_W'(1);
            mode_max    <= cfg_max;
            mode_signed <= cfg_signed;
         end else begin
            if (replace) acc <= in_data;
            cnt <= (&cnt) ? cnt : cnt + 1'b1;
         end
      end
   end
`ifdef MINMAX_REDUCE_ARGIDX_EN
   logic [CNT_W-1:0] idx;
   // cnt already saturates, so late replacements record the saturated index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) idx <= '0;
      else if (beat) begin
         if (state == IDLE) idx <= '0;
         else if (replace) idx <= cnt;
      end
   end
   assign out_index = out_valid ? idx : '0;
`else
   assign out_index = '0;
`endif
endmodule

// File: tb/tb_minmax_reduce_int.sv
// tb_minmax_reduce_int: randomized and directed frames checked against a queue-based reference model.
module tb_minmax_reduce_int;
   localparam int W = 32;
   localparam int CW = 4;
   localparam int SAT = (1 << CW) - 1;
   logic clk = 0, rst_n = 0, cfg_max = 0, cfg_signed = 0, in_valid = 0, in_last = 0, out_ready = 0;
   logic [W-1:0] in_data = '0;
   logic in_ready, out_valid;
   logic [W-1:0] out_data;
   logic [CW-1:0] out_index, out_count;
   int tests = 0, fails = 0;
   logic [W-1:0] frame_q[$];

   minmax_reduce_int #(.WIDTH(W), .IMPL_TYPE(0), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_max(cfg_max), .cfg_signed(cfg_signed),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_count(out_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic longint key(input logic [W-1:0] v, input bit sg);
      return sg ? longint'($signed(v)) : longint'({32'b0, v});
   endfunction

   task automatic model(input bit mx, input bit sg, output logic [W-1:0] d, output int ix, output int c);
      int best = 0;
      for (int i = 1; i < frame_q.size(); i++)
         if (mx ? key(frame_q[i], sg) > key(frame_q[best], sg) : key(frame_q[i], sg) < key(frame_q[best], sg))
            best = i;
      d = frame_q[best];
`ifdef MINMAX_REDUCE_ARGIDX_EN
      ix = best > SAT ? SAT : best;
`else
      ix = 0;
`endif
      c = frame_q.size() > SAT ? SAT : frame_q.size();
   endtask

   // gap_mode: 0 none, 1 bubble before every non-first beat, 2 random bubbles
   task automatic do_frame(input bit mx, input bit sg, input int gap_mode, input int hold);
      logic [W-1:0] ed;
      int ei, ec;
      model(mx, sg, ed, ei, ec);
      cfg_max = mx;
      cfg_signed = sg;
      for (int i = 0; i < frame_q.size(); i++) begin
         if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
            in_valid = 0;
            in_data = $urandom;
            @(negedge clk);
         end
         check("in_ready_frame", in_ready, 1);
         in_valid = 1;
         in_data = frame_q[i];
         in_last = (i == frame_q.size() - 1);
         @(negedge clk);
         cfg_max = ~mx;
         cfg_signed = ~sg;
      end
      in_valid = 0;
      in_last = 0;
      check("out_valid_latency", out_valid, 1);
      check("out_data", out_data, ed);
      check("out_index", out_index, ei);
      check("out_count", out_count, ec);
      for (int h = 0; h < hold; h++) begin
         in_valid = 1;
         in_data = $urandom;
         @(negedge clk);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
         check("bp_out_data", out_data, ed);
         check("bp_out_index", out_index, ei);
         check("bp_out_count", out_count, ec);
      end
      out_ready = 1;
      @(negedge clk);
      in_valid = 0;
      out_ready = 0;
      check("drain_out_valid", out_valid, 0);
      check("drain_in_ready", in_ready, 1);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_data", out_data, 0);
      check("rst_out_index", out_index, 0);
      check("rst_out_count", out_count, 0);
      rst_n = 1;
      @(negedge clk);
      frame_q = '{32'd5, -32'sd3, 32'd7, -32'sd3};
      do_frame(0, 1, 0, 0);
      do_frame(1, 0, 0, 0);
      do_frame(1, 1, 0, 5);
      frame_q = '{32'h8000_0000};
      do_frame(0, 1, 0, 0);
      frame_q = '{32'd10, 32'd2, 32'd9};
      do_frame(0, 1, 1, 0);
      do_frame(0, 0, 1, 2);
      // reset in the middle of a frame
      in_valid = 1;
      in_data = 100;
      @(negedge clk);
      in_data = 50;
      @(negedge clk);
      in_valid = 0;
      rst_n = 0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_data", out_data, 0);
      check("midrst_out_count", out_count, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      frame_q = '{32'd4};
      do_frame(1, 1, 0, 0);
      // saturation: 20 equal-ish beats with the extremum placed late
      frame_q.delete();
      for (int i = 0; i < 20; i++) frame_q.push_back(32'd50 - 32'(i));
      do_frame(0, 0, 0, 0);
      for (int f = 0; f < 60; f++) begin
         int n = $urandom_range(1, 20);
         frame_q.delete();
         for (int i = 0; i < n; i++) begin
            logic [W-1:0] v;
            case ($urandom_range(0, 5))
               0: v = 32'h8000_0000;
               1: v = 32'h7FFF_FFFF;
               2: v = 32'($urandom_range(0, 3)) - 32'd1;
               default: v = $urandom;
            endcase
            frame_q.push_back(v);
         end
         do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, $urandom_range(0, 2));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/minmax_reduce_int.md
Name: minmax_reduce_int

Overview:
Streaming signed/unsigned min/max reduction engine. Successor to the two-operand integer min benchmark.
- Consumes a frame of WIDTH-bit operands over a valid/ready input stream.
- Keeps a running extremum plus the index of its first occurrence.
- Emits one result per frame on a valid/ready output.
- Sits in the PIM synthesis benchmark set, instantiating the shared gt_int_nbit comparator, which receives the IMPL_TYPE parameter.

Parameters:
WIDTH, 32, operand and result width in bits (>=2)
IMPL_TYPE, 0, comparator implementation select, passed to gt_int_nbit
CNT_W, 16, width of element counter and index outputs

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cfg_max  input  1  0 = min reduction, 1 = max reduction; sampled on first beat of frame
cfg_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled on first beat
in_valid  input  1  input beat valid
in_ready  output  1  engine can accept beat
in_data  input  WIDTH  operand
in_last  input  1  marks final beat of frame
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  extremum of frame
out_index  output  CNT_W  zero-based position of first occurrence of extremum
out_count  output  CNT_W  number of beats in frame, saturating

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE.
  - out_valid=0, in_ready=1.
  - out_data=0, out_index=0, out_count=0.
  - Internal acc, cnt, mode regs = 0.
- States:
  - IDLE: in_ready=1. On beat (in_valid&in_ready): acc<=in_data, idx<=0, cnt<=1; latch cfg_max/cfg_signed. Go to DONE if in_last, else ACCUM.
  - ACCUM: in_ready=1. On beat, compare in_data against acc under latched mode:
    - min: replace iff acc > in_data.
    - max: replace iff in_data > acc.
    - Ties never replace, so the earliest index wins.
    - On replace: acc<=in_data, idx<=cnt. Then cnt<=cnt+1.
    - in_last beat -> DONE.
  - DONE: in_ready=0, out_valid=1; out_data/out_index/out_count show acc/idx/cnt. On out_ready -> IDLE, out_valid=0 next cycle.
- Latency: result visible the cycle after the in_last beat is accepted. Throughput is one frame per (N+1) cycles minimum.
- Outputs hold stable while out_valid=1 and out_ready=0.
- cfg_* changes mid-frame are ignored.
- Unsigned mode: implemented by inverting the MSB of both operands before the signed comparator. No second comparator.
- Counter saturates at 2^CNT_W-1. Beats beyond saturation are still compared, but idx is recorded as the saturated value.
- in_valid=0 cycles inside a frame: no state change, bubbles allowed.
- Single-beat frame: result is that operand, index 0, count 1.
- Reset asserted mid-frame or in DONE: partial result discarded, outputs take reset values immediately.

Optional Feature:
MINMAX_REDUCE_ARGIDX_EN
- Defined: idx register and replace-index logic present; out_index as specified.
- Undefined: idx register removed, out_index tied to 0. All other behaviour, including tie handling and count, is unchanged.

Test Plan:
- Signed min, WIDTH=32: frame {5, -3, 7, -3(last)} -> out_data=0xFFFFFFFD, out_index=1, out_count=4, out_valid the cycle after the last beat.
- Unsigned max, same frame -> out_data=0xFFFFFFFD (first -3), out_index=1; signed max on same frame -> out_data=7, out_index=2.
- Single beat 0x80000000 with in_last, cfg_signed=1, cfg_max=0 -> out_data=0x80000000, index 0, count 1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 throughout, outputs stable. Release -> out_valid drops, next frame accepted.
- Bubbles plus mid-frame cfg toggle: frame {10, gap, 2, gap, 9(last)} under min, with cfg_max flipped after beat 0 -> out_data=2, index 1, count 3.
- Assert rst_n=0 after 2 beats of a frame -> outputs zero, in_ready=1. A new frame {4(last)} yields out_data=4, count 1.
